// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and types for the instruction fetch unit
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [5:0]  OPCODE_J           = 6'b000010;
    localparam int          IMEM_DEPTH_DEFAULT = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - next-PC priority mux (jump > branch > stall > sequential) with range check
module if_next_pc
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] pc_cand,
    output logic [ADDR_W-1:0] pc_seq,
    output logic              cand_in_range
);

    logic [ADDR_W-1:0] jump_pc;

    always_comb begin
        pc_seq   = pc + 1'b1;
        // J-format keeps the upper PC bits and replaces the low 26
        jump_pc  = {pc[ADDR_W-1:26], jump_target};
        redirect = jump | branch_taken;
        if (jump) begin
            pc_cand = jump_pc;
        end else if (branch_taken) begin
            pc_cand = branch_target;
        end else if (stall) begin
            pc_cand = pc;
        end else begin
            pc_cand = pc_seq;
        end
        cand_in_range = (pc_cand < ADDR_W'(IMEM_DEPTH));
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC ownership, RUN/HALT control and IF/ID pipeline register
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int RESET_PC   = 0,
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_next_out,
    output logic              valid_out,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic              valid_q, valid_d;
    logic [31:0]       count_q, count_d;

    logic              redirect;
    logic [ADDR_W-1:0] pc_cand;
    logic [ADDR_W-1:0] pc_seq;
    logic              cand_in_range;

    if_next_pc #(
        .ADDR_W     (ADDR_W),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_next_pc (
        .pc            (pc_q),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .redirect      (redirect),
        .pc_cand       (pc_cand),
        .pc_seq        (pc_seq),
        .cand_in_range (cand_in_range)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (!cand_in_range) state_d = HALT;
            HALT:    if (redirect && cand_in_range) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        halted    = (state_q == HALT);
        imem_addr = pc_q;
    end

    // Out-of-range candidates never load the PC; in HALT only a redirect moves it
    always_comb begin
        pc_d = pc_q;
        if (state_q == RUN) begin
            if (cand_in_range) pc_d = pc_cand;
        end else if (redirect && cand_in_range) begin
            pc_d = pc_cand;
        end
    end

    always_comb begin
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        count_d   = count_q;
        if (state_q == HALT || redirect || flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d   = imem_instr;
            pc_out_d  = pc_q;
            pc_next_d = pc_seq;
            valid_d   = 1'b1;
            if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= ADDR_W'(RESET_PC);
            instr_q   <= NOP_INSTR;
            pc_out_q  <= '0;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_next_out = pc_next_q;
    assign valid_out   = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_target;
    logic [31:0] imem_addr, imem_instr, instr_out, pc_out, pc_next_out, fetch_count;
    logic        valid_out, halted;

    logic [31:0] mem [16];
    int          n_cmp = 0;
    int          n_err = 0;

    if_fetch_unit #(.RESET_PC(0), .IMEM_DEPTH(16), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .pc_next_out   (pc_next_out),
        .valid_out     (valid_out),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd16) ? mem[imem_addr[3:0]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h0022_1820;
        mem[1] = 32'h2109_000A;
        mem[5] = {OPCODE_J, 26'd3};

        rst = 1'b1; stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_target = 0;
        #2;
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pcout", pc_out, 32'd0);
        step();
        rst = 1'b0;

        step();
        chk("e1_instr", instr_out, 32'h0022_1820);
        chk("e1_pc", pc_out, 32'd0);
        chk("e1_pcnext", pc_next_out, 32'd1);
        chk("e1_valid", {31'd0, valid_out}, 32'd1);
        step();
        chk("e2_instr", instr_out, 32'h2109_000A);
        chk("e2_pc", pc_out, 32'd1);
        chk("e2_count", fetch_count, 32'd2);

        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_addr", imem_addr, 32'd2);
            chk("stall_pc", pc_out, 32'd1);
            chk("stall_instr", instr_out, 32'h2109_000A);
            chk("stall_count", fetch_count, 32'd2);
        end
        stall = 0;
        step();
        chk("unstall_pc", pc_out, 32'd2);
        chk("unstall_instr", instr_out, 32'h1000_0002);
        chk("unstall_count", fetch_count, 32'd3);

        branch_taken = 1; branch_target = 6;
        step();
        branch_taken = 0;
        chk("br_valid", {31'd0, valid_out}, 32'd0);
        chk("br_instr", instr_out, 32'h0);
        chk("br_addr", imem_addr, 32'd6);
        chk("br_pc_hold", pc_out, 32'd2);
        step();
        chk("br_tgt_pc", pc_out, 32'd6);
        chk("br_tgt_valid", {31'd0, valid_out}, 32'd1);
        chk("br_tgt_count", fetch_count, 32'd4);

        jump = 1; jump_target = 12; branch_taken = 1; branch_target = 4;
        step();
        jump = 0; branch_taken = 0;
        chk("jmp_addr", imem_addr, 32'd12);
        chk("jmp_valid", {31'd0, valid_out}, 32'd0);
        step();
        chk("jmp_pc", pc_out, 32'd12);
        chk("jmp_count", fetch_count, 32'd5);

        step(); step(); step();
        chk("w15_pc", pc_out, 32'd15);
        chk("w15_valid", {31'd0, valid_out}, 32'd1);
        chk("w15_halted", {31'd0, halted}, 32'd1);
        chk("w15_addr", imem_addr, 32'd15);
        chk("w15_count", fetch_count, 32'd8);
        stall = 1;
        step();
        stall = 0;
        chk("halt_valid", {31'd0, valid_out}, 32'd0);
        chk("halt_addr", imem_addr, 32'd15);
        chk("halt_count", fetch_count, 32'd8);

        jump = 1; jump_target = 20;
        step();
        chk("oor_jmp_halted", {31'd0, halted}, 32'd1);
        chk("oor_jmp_addr", imem_addr, 32'd15);
        jump_target = 0;
        step();
        jump = 0;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_addr", imem_addr, 32'd0);
        chk("resume_valid", {31'd0, valid_out}, 32'd0);
        step();
        chk("resume_instr", instr_out, 32'h0022_1820);
        chk("resume_count", fetch_count, 32'd9);

        branch_taken = 1; branch_target = 100;
        step();
        branch_taken = 0;
        chk("oor_br_halted", {31'd0, halted}, 32'd1);
        chk("oor_br_addr", imem_addr, 32'd1);
        chk("oor_br_valid", {31'd0, valid_out}, 32'd0);

        flush = 1;
        #3 rst = 1'b1;
        #1;
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        chk("arst_pc", pc_out, 32'd0);
        @(negedge clk);
        rst = 1'b0; flush = 0;
        step();
        chk("rs_instr", instr_out, 32'h0022_1820);
        chk("rs_count", fetch_count, 32'd1);

        flush = 1; stall = 1;
        step();
        flush = 0; stall = 0;
        chk("fs_valid", {31'd0, valid_out}, 32'd0);
        chk("fs_pc", pc_out, 32'd0);
        chk("fs_addr", imem_addr, 32'd1);
        chk("fs_count", fetch_count, 32'd1);
        step();
        chk("fs_next_pc", pc_out, 32'd1);
        chk("fs_next_instr", instr_out, 32'h2109_000A);
        chk("fs_next_count", fetch_count, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
